// File: rtl/status_register_pkg.sv
// Shared definitions for the NZCV status register:
// condition-code encodings and flag bit positions.
package status_register_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/status_register.sv
// CPSR/SPSR NZCV flags with EX->ID bypass or
// hazard stall, plus a saturating stall counter.
module status_register
  import status_register_pkg::*;
#(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ex_valid,
  input  logic             ex_s,
  input  logic [3:0]       ex_nzcv,
  input  logic             ex_freeze,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [3:0]       id_cond,
  input  logic             exc_entry,
  input  logic             exc_return,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic [3:0]       cpsr,
  output logic [3:0]       spsr,
  output logic             flag_stall,
  output logic             proto_err,
  output logic [CNT_W-1:0] stall_cnt
);

  logic       commit;
  logic       ex_pending;
  logic       needs_flags;
  logic [3:0] cpsr_nxt;
  logic [3:0] flags;

  assign ex_pending  = ex_valid & ex_s & ~flush;
  assign commit      = ex_pending & ~ex_freeze;
  assign needs_flags = id_valid
                     & (id_cond != COND_AL)
                     & (id_cond != COND_NV);

  always_comb begin
    cpsr_nxt = cpsr;
    if (exc_return)  cpsr_nxt = spsr;
    else if (commit) cpsr_nxt = ex_nzcv;
  end

  // Return outranks both the bypass and the stall.
  always_comb begin
    flags      = cpsr;
    flag_stall = 1'b0;
    if (exc_return) begin
      flags = spsr;
    end else if (FWD_EN) begin
      if (ex_pending) flags = ex_nzcv;
    end else begin
      flag_stall = needs_flags & ex_pending;
    end
  end

  assign N = flags[FLAG_N];
  assign Z = flags[FLAG_Z];
  assign C = flags[FLAG_C];
  assign V = flags[FLAG_V];

  always_ff @(posedge CLK) begin
    if (RST) begin
      cpsr      <= '0;
      spsr      <= '0;
      proto_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      cpsr <= cpsr_nxt;
      if (exc_entry & ~exc_return)
        spsr <= cpsr_nxt;
      if (exc_entry & exc_return)
        proto_err <= 1'b1;
      if (flag_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_status_register.sv
// Scoreboard bench: a forwarding and a stalling
// status_register share stimulus against a flag model.
module tb_status_register;
  import status_register_pkg::*;

  localparam int SCW  = 3;
  localparam int SMAX = (1 << SCW) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_valid, ex_s, ex_freeze, flush;
  logic [3:0] ex_nzcv;
  logic       id_valid;
  logic [3:0] id_cond;
  logic       exc_entry, exc_return;

  logic        fN, fZ, fC, fV, f_stall, f_perr;
  logic [3:0]  f_cpsr, f_spsr;
  logic [15:0] f_cnt;
  logic        sN, sZ, sC, sV, s_stall, s_perr;
  logic [3:0]  s_cpsr, s_spsr;
  logic [SCW-1:0] s_cnt;

  always #5 clk = ~clk;

  status_register #(.FWD_EN(1'b1), .CNT_W(16)) u_fwd (
    .CLK(clk), .RST(rst),
    .ex_valid(ex_valid), .ex_s(ex_s), .ex_nzcv(ex_nzcv),
    .ex_freeze(ex_freeze), .flush(flush),
    .id_valid(id_valid), .id_cond(id_cond),
    .exc_entry(exc_entry), .exc_return(exc_return),
    .N(fN), .Z(fZ), .C(fC), .V(fV),
    .cpsr(f_cpsr), .spsr(f_spsr),
    .flag_stall(f_stall), .proto_err(f_perr),
    .stall_cnt(f_cnt)
  );

  status_register #(.FWD_EN(1'b0), .CNT_W(SCW)) u_stl (
    .CLK(clk), .RST(rst),
    .ex_valid(ex_valid), .ex_s(ex_s), .ex_nzcv(ex_nzcv),
    .ex_freeze(ex_freeze), .flush(flush),
    .id_valid(id_valid), .id_cond(id_cond),
    .exc_entry(exc_entry), .exc_return(exc_return),
    .N(sN), .Z(sZ), .C(sC), .V(sV),
    .cpsr(s_cpsr), .spsr(s_spsr),
    .flag_stall(s_stall), .proto_err(s_perr),
    .stall_cnt(s_cnt)
  );

  typedef struct {
    logic [3:0]  fl_f;
    logic [3:0]  fl_s;
    logic        st_f;
    logic        st_s;
    logic [3:0]  cpsr;
    logic [3:0]  spsr;
    logic        perr;
    logic [15:0] cnt_f;
    logic [15:0] cnt_s;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Architectural model state
  int m_cpsr, m_spsr, m_perr, m_cnt_s;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per cycle the DUTs present outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("fwd_flags", {fN, fZ, fC, fV}, e.fl_f);
        cmp("stl_flags", {sN, sZ, sC, sV}, e.fl_s);
        cmp("fwd_stall", f_stall, e.st_f);
        cmp("stl_stall", s_stall, e.st_s);
        cmp("fwd_cpsr", f_cpsr, e.cpsr);
        cmp("stl_cpsr", s_cpsr, e.cpsr);
        cmp("fwd_spsr", f_spsr, e.spsr);
        cmp("stl_spsr", s_spsr, e.spsr);
        cmp("fwd_perr", f_perr, e.perr);
        cmp("stl_perr", s_perr, e.perr);
        cmp("fwd_cnt", f_cnt, e.cnt_f);
        cmp("stl_cnt", s_cnt, e.cnt_s);
      end
    end
  end

  task automatic step(
    input bit r, input bit v, input bit s,
    input bit [3:0] nz, input bit frz, input bit fl,
    input bit idv, input bit [3:0] cond,
    input bit ent, input bit ret, input bit chk
  );
    exp_t e;
    bit pend, wr, need, st;
    int nc;
    @(posedge clk);
    #1;
    rst = r; ex_valid = v; ex_s = s; ex_nzcv = nz;
    ex_freeze = frz; flush = fl; id_valid = idv;
    id_cond = cond; exc_entry = ent; exc_return = ret;
    pend = v && s && !fl;
    wr   = pend && !frz;
    need = idv && cond != 4'd14 && cond != 4'd15;
    st   = need && pend && !ret;
    if (chk) begin
      e.fl_f  = ret ? m_spsr[3:0] :
                pend ? nz : m_cpsr[3:0];
      e.fl_s  = ret ? m_spsr[3:0] : m_cpsr[3:0];
      e.st_f  = 1'b0;
      e.st_s  = st;
      e.cpsr  = m_cpsr[3:0];
      e.spsr  = m_spsr[3:0];
      e.perr  = m_perr[0];
      e.cnt_f = 16'd0;
      e.cnt_s = 16'(m_cnt_s);
      sb.push_back(e);
    end
    if (r) begin
      m_cpsr = 0; m_spsr = 0; m_perr = 0; m_cnt_s = 0;
    end else begin
      nc = ret ? m_spsr : (wr ? int'(nz) : m_cpsr);
      if (ent && !ret) m_spsr = nc;
      if (ent && ret)  m_perr = 1;
      if (st && m_cnt_s < SMAX) m_cnt_s++;
      m_cpsr = nc;
    end
  endtask

  task automatic idle(input bit [3:0] cond);
    step(0, 0, 0, 0, 0, 0, 1, cond, 0, 0, 1);
  endtask

  task automatic op(input bit [3:0] nz, input bit frz,
                    input bit fl, input bit ent, input bit ret);
    step(0, 1, 1, nz, frz, fl, 1, COND_EQ, ent, ret, 1);
  endtask

  initial begin
    int n;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(COND_EQ);
    // Hazard with EQ reading a fresh Z
    op(4'b0100, 0, 0, 0, 0);
    idle(COND_EQ);
    // Frozen EX for three cycles, then commit
    op(4'b1000, 1, 0, 0, 0);
    op(4'b1000, 1, 0, 0, 0);
    op(4'b1000, 1, 0, 0, 0);
    op(4'b1000, 0, 0, 0, 0);
    idle(COND_EQ);
    // Flush kills the hazard
    op(4'b0001, 0, 1, 0, 0);
    idle(COND_EQ);
    // Entry sees same-cycle commit; return beats commit
    op(4'b1001, 0, 0, 0, 0);
    op(4'b0010, 0, 0, 1, 0);
    idle(COND_EQ);
    op(4'b0110, 0, 0, 0, 0);
    op(4'b1111, 0, 0, 0, 1);
    idle(COND_EQ);
    // Illegal entry+return
    op(4'b0101, 0, 0, 1, 1);
    idle(COND_AL);
    // Reset in the middle of a frozen stall
    op(4'b1100, 1, 0, 0, 0);
    step(1, 1, 1, 4'b1100, 1, 0, 1, COND_NE, 0, 0, 1);
    idle(COND_NE);
    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      n = $urandom_range(0, 99);
      step(n == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0,
           4'($urandom),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) != 0,
           4'($urandom),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 11) == 0,
           1);
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/status_register.md
# status_register

Holds the processor's architectural NZCV flags (CPSR condition field) and a saved copy (SPSR) for exception entry/return. It sits in ID, directly upstream of the condition-check logic, and drives its `N`, `Z`, `C`, `V` inputs. It commits flags written back by flag-setting (S-bit) instructions in EX and either bypasses in-flight flags or stalls ID when a conditional instruction would read stale flags. It also counts flag-hazard stall cycles for performance debug.

## Interface
Parameters:
- `FWD_EN`, default 1: 1 = bypass EX flags to ID; 0 = stall ID on a flag hazard.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `CLK` in 1: the single clock; all state updates on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `ex_valid` in 1: EX holds a live instruction.
- `ex_s` in 1: the EX instruction sets flags (S bit).
- `ex_nzcv` in 4: ALU flags from EX, bit order {N,Z,C,V}.
- `ex_freeze` in 1: EX is held this cycle; no commit.
- `flush` in 1: kill the EX instruction this cycle; no commit, no bypass.
- `id_valid` in 1: ID holds a live instruction.
- `id_cond` in 4: condition field of the ID instruction.
- `exc_entry` in 1: copy CPSR flags into SPSR.
- `exc_return` in 1: restore CPSR flags from SPSR.
- `N`, `Z`, `C`, `V` out 1 each: flags presented to condition check.
- `cpsr` out 4: registered architectural flags {N,Z,C,V}.
- `spsr` out 4: registered saved flags.
- `flag_stall` out 1: stall request to the ID/IF pipeline registers.
- `proto_err` out 1: sticky flag for an illegal simultaneous `exc_entry` and `exc_return`.
- `stall_cnt` out `CNT_W`: saturating count of cycles with `flag_stall`=1.

## Operation
- `commit` = `ex_valid & ex_s & ~flush & ~ex_freeze`.
- `ex_pending` = `ex_valid & ex_s & ~flush`. This is independent of `ex_freeze`.
- `needs_flags` = `id_valid & (id_cond != 4'b1110) & (id_cond != 4'b1111)`.
- CPSR next-state priority:
  - `RST` → 0.
  - else `exc_return` → `spsr`.
  - else `commit` → `ex_nzcv`.
  - else hold.
- SPSR next state:
  - `RST` → 0.
  - else `exc_entry & ~exc_return` → the CPSR value written this cycle, i.e. a same-cycle commit is included.
  - else hold.
- `exc_entry & exc_return` together: the return takes effect, the entry is ignored, and `proto_err` sets. `proto_err` clears only on `RST`.
- Flag outputs:
  - `FWD_EN`=1: `{N,Z,C,V}` = `ex_pending ? ex_nzcv : cpsr`. `flag_stall` is always 0.
  - `FWD_EN`=0: `{N,Z,C,V}` = `cpsr`. `flag_stall` = `needs_flags & ex_pending`.
- An exception return overrides the bypass: while `exc_return`=1, `{N,Z,C,V}` = `spsr`, and `flag_stall` is 0.
- `stall_cnt` increments each cycle `flag_stall`=1, saturates at all-ones, and clears on `RST`.

## Timing
- Reset values: `cpsr`=0, `spsr`=0, `proto_err`=0, `stall_cnt`=0, `flag_stall`=0. `N`/`Z`/`C`/`V` are 0 unless a bypass is active.
- `N`/`Z`/`C`/`V` and `flag_stall` are combinational, with zero-cycle latency from the EX/ID inputs.
- `cpsr` and `spsr` update one cycle after `commit` or an exception event.
- `FWD_EN`=0 hazard:
  - Stall lasts exactly 1 cycle when `ex_freeze`=0.
  - While `ex_freeze`=1, the stall persists.
  - The first cycle after the commit edge, `cpsr` holds the new flags and the stall drops.
- `flush` in the same cycle as a hazard: no stall and no commit.
- `RST` mid-stall: all state clears on that edge, and the next cycle behaves as after reset.

## Structure
- Shared package contents:
  - condition codes `COND_EQ`..`COND_AL`, `COND_NV` (4'b1111)
  - NZCV bit indices `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0
- No sub-module. A single module holds the CPSR/SPSR registers, the hazard logic, and the counter.

## Test plan
- Reset, then check outputs: `cpsr`=0, `spsr`=0, `stall_cnt`=0, `flag_stall`=0.
- `FWD_EN`=1, ex_valid=1, ex_s=1, ex_nzcv=4'b0100, id_cond=EQ → Z=1 in the same cycle; `cpsr`=4'b0100 in the next cycle.
- `FWD_EN`=0, same stimulus → `flag_stall`=1 for 1 cycle, `stall_cnt`=1, then Z=1 from `cpsr`.
- `FWD_EN`=0 with `ex_freeze`=1 for 3 cycles → stall for 4 cycles, `stall_cnt`=4; `flush` instead → no stall, `cpsr` unchanged.
- `cpsr`=4'b1001, `exc_entry` plus commit of 4'b0010 in the same cycle → `spsr`=4'b0010. Later, `exc_return` plus a commit of 4'b1111 → `cpsr`=4'b0010.
- `exc_entry` and `exc_return` in the same cycle → `proto_err`=1, `spsr` unchanged, `cpsr`=`spsr`.
